// File: rtl/regfile_decoded.sv
// Multi-read, single-write register file with one-hot write decoder,
// optional zero register, optional write bypass and sequenced clear engine.
module regfile_decoded #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     clr_req,
    output logic                     busy,
    output logic [2**ADDR_W-1:0]     wsel_oh
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_busy;
    logic                w_wr_ok;
    logic [DEPTH-1:0]    w_wsel;

    assign w_busy  = (r_state == S_CLEAR);
    assign w_wr_ok = we & ~w_busy;
    assign busy    = w_busy;
    assign wsel_oh = w_wsel;

    always_comb begin
        w_wsel = '0;
        if (w_wr_ok) begin
            w_wsel[waddr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_wsel[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Exit is an explicit compare against the last index, never overflow.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (w_busy && (r_cnt == ADDR_W'(k))) begin
                    r_mem[k] <= '0;
                end else if (w_wsel[k]) begin
                    r_mem[k] <= wdata;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = raddr[gi*ADDR_W +: ADDR_W];

        // Later assignments take priority: zero reg beats bypass beats storage.
        always_comb begin
            w_rd = r_mem[w_ra];
            if ((BYPASS != 0) && w_wsel[w_ra]) begin
                w_rd = wdata;
            end
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rd = '0;
            end
        end

        assign rdata[gi*DATA_W +: DATA_W] = w_rd;
    end

endmodule

// File: tb/tb_regfile_decoded.sv
// Directed bench for regfile_decoded: one instance with zero reg and bypass,
// one with both disabled, driven by the same stimulus.
module tb_regfile_decoded;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [5:0]  raddr;
    logic        clr_req;

    logic [63:0] rdata_a;
    logic        busy_a;
    logic [7:0]  wsel_a;
    logic [63:0] rdata_b;
    logic        busy_b;
    logic [7:0]  wsel_b;

    int n_chk;
    int n_fail;

    regfile_decoded #(
        .DATA_W(32), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_a), .clr_req(clr_req),
        .busy(busy_a), .wsel_oh(wsel_a)
    );

    regfile_decoded #(
        .DATA_W(32), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .clr_req(clr_req),
        .busy(busy_b), .wsel_oh(wsel_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [2:0] wa,
                         input logic [31:0] wd, input logic [2:0] r0,
                         input logic [2:0] r1, input logic cr);
        @(posedge clk);
        #1;
        we      = w;
        waddr   = wa;
        wdata   = wd;
        raddr   = {r1, r0};
        clr_req = cr;
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [2:0]  r0;
        logic [2:0]  r1;
        logic [7:0]  ws_a;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [7:0]  ws_b;
        logic [31:0] b0;
        logic [31:0] b1;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 3'd5, 32'hDEADBEEF, 3'd5, 3'd0,
                    8'h20, 32'hDEADBEEF, 32'h0, 8'h20, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 3'd0, 32'h0, 3'd5, 3'd4,
                    8'h00, 32'hDEADBEEF, 32'h0, 8'h00, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 3'd0, 32'h1234, 3'd0, 3'd0,
                    8'h00, 32'h0, 32'h0, 8'h01, 32'h0, 32'h0};
        vecs[3] = '{1'b0, 3'd0, 32'h0, 3'd0, 3'd5,
                    8'h00, 32'h0, 32'hDEADBEEF, 8'h00, 32'h1234, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 3'd3, 32'h11, 3'd3, 3'd3,
                    8'h08, 32'h11, 32'h11, 8'h08, 32'h0, 32'h0};
        vecs[5] = '{1'b1, 3'd3, 32'h22, 3'd3, 3'd3,
                    8'h08, 32'h22, 32'h22, 8'h08, 32'h11, 32'h11};
        vecs[6] = '{1'b0, 3'd0, 32'h0, 3'd3, 3'd3,
                    8'h00, 32'h22, 32'h22, 8'h00, 32'h22, 32'h22};
        vecs[7] = '{1'b1, 3'd7, 32'h77, 3'd7, 3'd6,
                    8'h80, 32'h77, 32'h0, 8'h80, 32'h0, 32'h0};
        vecs[8] = '{1'b0, 3'd0, 32'h0, 3'd7, 3'd0,
                    8'h00, 32'h77, 32'h0, 8'h00, 32'h77, 32'h1234};

        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        raddr   = '0;
        clr_req = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        chk("rst_wsel_a", 32'(wsel_a), 32'd0);
        chk("rst_wsel_b", 32'(wsel_b), 32'd0);
        for (int a = 0; a < 8; a++) begin
            raddr = {3'(7 - a), 3'(a)};
            #1;
            chk("rst_rd_a0", rdata_a[31:0], 32'h0);
            chk("rst_rd_b1", rdata_b[63:32], 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven write/read/bypass/zero-register vectors
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].w, vecs[i].wa, vecs[i].wd, vecs[i].r0,
                  vecs[i].r1, 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d_wsel_a", i), 32'(wsel_a), 32'(vecs[i].ws_a));
            chk($sformatf("v%0d_a0", i), rdata_a[31:0], vecs[i].a0);
            chk($sformatf("v%0d_a1", i), rdata_a[63:32], vecs[i].a1);
            chk($sformatf("v%0d_wsel_b", i), 32'(wsel_b), 32'(vecs[i].ws_b));
            chk($sformatf("v%0d_b0", i), rdata_b[31:0], vecs[i].b0);
            chk($sformatf("v%0d_b1", i), rdata_b[63:32], vecs[i].b1);
        end

        // Untouched entries 1,2,4 still read zero
        drive(1'b0, 3'd0, 32'h0, 3'd1, 3'd2, 1'b0);
        @(negedge clk);
        chk("idle_e1", rdata_a[31:0], 32'h0);
        chk("idle_e2", rdata_a[63:32], 32'h0);

        // Fill entries with k+1
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'(k), 32'(k + 1), 3'd7, 3'd2, 1'b0);
        end

        // clr_req together with a write of 0xAA to entry 2
        drive(1'b1, 3'd2, 32'hAA, 3'd7, 3'd2, 1'b1);
        @(negedge clk);
        chk("clr_cyc_busy", 32'(busy_a), 32'd0);
        chk("clr_cyc_wsel", 32'(wsel_a), 32'h04);
        chk("clr_cyc_e7", rdata_b[31:0], 32'd8);

        for (int c = 1; c <= 10; c++) begin
            logic        w;
            logic [2:0]  r1;
            logic        cr;
            logic [31:0] e0;
            logic [31:0] e1;
            w  = (c == 2);
            r1 = (c == 2 || c == 3) ? 3'd6 : 3'd2;
            cr = (c == 5);
            drive(w, 3'd6, 32'h66, 3'd7, r1, cr);
            @(negedge clk);
            e0 = (c <= 8) ? 32'd8 : 32'd0;
            if (c == 1)
                e1 = 32'hAA;
            else if (c <= 3)
                e1 = 32'd7;
            else
                e1 = 32'd0;
            chk($sformatf("clr%0d_busy_a", c), 32'(busy_a), 32'(c <= 8));
            chk($sformatf("clr%0d_busy_b", c), 32'(busy_b), 32'(c <= 8));
            chk($sformatf("clr%0d_e7_a", c), rdata_a[31:0], e0);
            chk($sformatf("clr%0d_p1_a", c), rdata_a[63:32], e1);
            chk($sformatf("clr%0d_p1_b", c), rdata_b[63:32], e1);
            if (c == 2) begin
                chk("busy_wsel_a", 32'(wsel_a), 32'h0);
                chk("busy_wsel_b", 32'(wsel_b), 32'h0);
            end
        end

        for (int a = 0; a < 8; a++) begin
            raddr = {3'(a), 3'(a)};
            #1;
            chk("post_clr_a", rdata_a[31:0], 32'h0);
            chk("post_clr_b", rdata_b[63:32], 32'h0);
        end

        // Async reset in the middle of a clear
        drive(1'b1, 3'd5, 32'h55, 3'd5, 3'd5, 1'b0);
        drive(1'b0, 3'd0, 32'h0, 3'd5, 3'd5, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            drive(1'b0, 3'd0, 32'h0, 3'd5, 3'd5, 1'b0);
        end
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy_a), 32'd1);
        chk("pre_rst_e5", rdata_b[31:0], 32'h55);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy_a", 32'(busy_a), 32'd0);
        chk("async_busy_b", 32'(busy_b), 32'd0);
        chk("async_e5_a", rdata_a[31:0], 32'h0);
        chk("async_e5_b", rdata_b[31:0], 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        drive(1'b0, 3'd0, 32'h0, 3'd5, 3'd5, 1'b1);
        @(negedge clk);
        chk("reclr_req_busy", 32'(busy_a), 32'd0);
        for (int c = 1; c <= 10; c++) begin
            drive(1'b0, 3'd0, 32'h0, 3'd5, 3'd5, 1'b0);
            @(negedge clk);
            chk($sformatf("reclr%0d_busy_a", c), 32'(busy_a), 32'(c <= 8));
            chk($sformatf("reclr%0d_busy_b", c), 32'(busy_b), 32'(c <= 8));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_decoded.md
Name: regfile_decoded

Overview:
Parametrised multi-read, single-write register file. Its write path uses an internal one-hot address decoder, generalised from a fixed 3-to-8 decoder to ADDR_W-to-2^ADDR_W. Adds configurable read-port count, an optional hardwired zero register, optional write-to-read bypass, and a sequenced clear engine. Sits in the RegisterFile datapath as the architectural register store.

Parameters:
DATA_W, 32, width of each register entry in bits
ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of independent combinational read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is ordinary
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = reads show stored contents only

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
raddr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  packed read data; port i = bits [i*DATA_W +: DATA_W]
clr_req  in  1  single-cycle request to zero all entries
busy  out  1  high while the clear engine runs
wsel_oh  out  2**ADDR_W  one-hot decoded write select, combinational, for debug and coverage

Behaviour:
- Reset (rst_n=0, async): all entries = 0, FSM = IDLE, clear counter = 0, busy = 0. Reset is released synchronously by the integrator. wsel_oh and rdata are combinational; with we=0 they read 0 and the stored value 0.
- Write accepted: wr_ok = we & ~busy.
- wsel_oh = wr_ok ? (1 << waddr) : 0.
  - When ZERO_REG=1, bit 0 of wsel_oh is forced to 0.
  - wsel_oh is never more than one-hot.
- Rising edge: every entry k with wsel_oh[k]=1 loads wdata. Write latency is 1 cycle to storage.
- Read, per port i, purely combinational (0-cycle):
  - If ZERO_REG=1 and raddr_i = 0: rdata_i = 0.
  - Else if BYPASS=1 and wsel_oh[raddr_i]=1: rdata_i = wdata.
  - Else: rdata_i = entry[raddr_i].
  - All ports are independent; identical addresses on several ports are legal.
- Clear FSM has two states, IDLE and CLEAR.
  - IDLE: busy=0. If clr_req=1, go to CLEAR with cnt=0. A write in the same cycle is still accepted.
  - CLEAR: busy=1. Each cycle, entry[cnt] <= 0. If cnt = DEPTH-1, go to IDLE; else cnt <= cnt+1.
  - Clear occupies exactly DEPTH cycles. busy rises the cycle after clr_req is sampled.
  - clr_req while in CLEAR is ignored (not queued).
  - we while busy=1 is dropped silently. wsel_oh = 0 and bypass is inactive.
  - Reads during CLEAR return current contents: entries below cnt read 0, the rest read old values.
- Wrap-around: cnt has width ADDR_W and never increments past DEPTH-1. The exit condition is explicit, not overflow.
- Reset mid-clear: asynchronous return to the reset state; clear is abandoned (all entries are already 0).
- No X-propagation: an out-of-range address is impossible by width.

Test Plan:
1. Reset then write/read: rst_n low 3 cycles, then write 0xDEADBEEF to addr 5 → wsel_oh=0x20 during the write cycle; the next cycle rdata0 with raddr0=5 = 0xDEADBEEF; the other 7 entries read 0.
2. Zero register: ZERO_REG=1, we=1, waddr=0, wdata=0x1234 → wsel_oh=0x00; raddr0=0 reads 0 both same cycle and after. With ZERO_REG=0 the same write reads back 0x1234.
3. Bypass: BYPASS=1, addr 3 holds 0x11, write 0x22 to addr 3 with raddr0=raddr1=3 → both ports show 0x22 in the same cycle. With BYPASS=0, they show 0x11 that cycle and 0x22 the next.
4. Clear sequence: fill all 8 entries with k+1, pulse clr_req → busy high for exactly 8 cycles starting the next cycle. raddr0=7 reads 8 until the 8th busy cycle's edge, then 0. All entries read 0 after busy falls.
5. Collisions: clr_req and a write of 0xAA to addr 2 in the same IDLE cycle → write lands, then is zeroed. A write attempted during busy → wsel_oh=0 and the entry is unchanged. A second clr_req during busy does not extend busy beyond 8 cycles.
6. Async reset mid-clear: assert rst_n at clear cycle 4 without a clock edge → busy=0 immediately; after release, clr_req again yields a full 8-cycle busy window.
